// File: rtl/te_frame_sched.sv
// Tearing-effect timebase with shadowed configuration and a req/ack/done frame scheduler.
// Optional external TE phase lock is compiled in when TE_EXT_SYNC_EN is defined.
module te_frame_sched #(
   parameter int unsigned CNT_W        = 23,
   parameter int unsigned DEF_PERIOD   = 1334333,
   parameter int unsigned DEF_TE_START = 100,
   parameter int unsigned DEF_TE_END   = 300
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_te_start,
   input  logic [CNT_W-1:0] cfg_te_end,
   input  logic             cfg_load,
`ifdef TE_EXT_SYNC_EN
   input  logic             te_ext,
`endif
   output logic             te,
   output logic             frame_req,
   input  logic             frame_ack,
   input  logic             frame_done,
   output logic             busy,
   output logic [15:0]      frame_cnt,
   output logic [7:0]       overrun_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_TE,
      ST_REQ,
      ST_BUSY
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_per_act;
   logic [CNT_W-1:0] r_ts_act;
   logic [CNT_W-1:0] r_tend_act;
   logic [CNT_W-1:0] r_per_pend;
   logic [CNT_W-1:0] r_ts_pend;
   logic [CNT_W-1:0] r_tend_pend;
   logic             r_te;
   logic             r_req;
   logic             r_busy;
   logic [15:0]      r_frame_cnt;
   logic [7:0]       r_ovr_cnt;

   logic             w_wrap;
   logic             w_sync;
   logic             w_reload;
   logic             w_te_evt;
   logic             w_frame_inc;
   logic             w_ovr_inc;

   assign w_wrap   = enable && (r_cnt == r_per_act);
   assign w_te_evt = enable && (r_cnt == r_tend_act);
   assign w_reload = !enable || w_wrap || w_sync;

`ifdef TE_EXT_SYNC_EN
   logic r_ext_meta;
   logic r_ext_sync;
   logic r_ext_prev;

   // Two-flop synchronizer plus one delay stage for rising-edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ext_meta <= 1'b0;
         r_ext_sync <= 1'b0;
         r_ext_prev <= 1'b0;
      end else begin
         r_ext_meta <= te_ext;
         r_ext_sync <= r_ext_meta;
         r_ext_prev <= r_ext_sync;
      end
   end

   assign w_sync = enable && r_ext_sync && !r_ext_prev;
`else
   assign w_sync = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (w_reload) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Active timing only changes at a frame boundary, so a frame never mixes old and new settings.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_per_act   <= CNT_W'(DEF_PERIOD);
         r_ts_act    <= CNT_W'(DEF_TE_START);
         r_tend_act  <= CNT_W'(DEF_TE_END);
         r_per_pend  <= CNT_W'(DEF_PERIOD);
         r_ts_pend   <= CNT_W'(DEF_TE_START);
         r_tend_pend <= CNT_W'(DEF_TE_END);
      end else begin
         if (w_reload) begin
            r_per_act  <= r_per_pend;
            r_ts_act   <= r_ts_pend;
            r_tend_act <= r_tend_pend;
         end
         if (cfg_load) begin
            r_per_pend  <= cfg_period;
            r_ts_pend   <= cfg_te_start;
            r_tend_pend <= cfg_te_end;
         end
      end
   end

   // Clear wins over set, so equal start and end points produce no pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_te <= 1'b0;
      end else if (!enable || w_wrap || (r_cnt == r_tend_act)) begin
         r_te <= 1'b0;
      end else if (r_cnt == r_ts_act) begin
         r_te <= 1'b1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_frame_inc = 1'b0;
      w_ovr_inc   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_next = ST_WAIT_TE;
         end
         ST_WAIT_TE: begin
            if (!enable)       w_next = ST_IDLE;
            else if (w_te_evt) w_next = ST_REQ;
         end
         ST_REQ: begin
            w_ovr_inc = w_te_evt;
            if (!enable)        w_next = ST_IDLE;
            else if (frame_ack) w_next = ST_BUSY;
         end
         ST_BUSY: begin
            if (frame_done) begin
               w_frame_inc = 1'b1;
               if (!enable)       w_next = ST_IDLE;
               else if (w_te_evt) w_next = ST_REQ;
               else               w_next = ST_WAIT_TE;
            end else begin
               w_ovr_inc = w_te_evt;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_req       <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_cnt <= '0;
         r_ovr_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_req   <= (w_next == ST_REQ);
         r_busy  <= (w_next == ST_REQ) || (w_next == ST_BUSY);
         if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_ovr_inc && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
   end

   assign te          = r_te;
   assign frame_req   = r_req;
   assign busy        = r_busy;
   assign frame_cnt   = r_frame_cnt;
   assign overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_te_frame_sched.sv
// Self-checking bench for te_frame_sched: directed scenarios plus a randomized run
// compared against a frame-position reference model.
module tb_te_frame_sched;

   localparam int CNT_W = 23;

   logic             clk;
   logic             rstn;
   logic             enable;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_te_start;
   logic [CNT_W-1:0] cfg_te_end;
   logic             cfg_load;
   logic             te;
   logic             frame_req;
   logic             frame_ack;
   logic             frame_done;
   logic             busy;
   logic [15:0]      frame_cnt;
   logic [7:0]       overrun_cnt;
`ifdef TE_EXT_SYNC_EN
   logic             te_ext = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   te_frame_sched dut (
      .clk         (clk),
      .rstn        (rstn),
      .enable      (enable),
      .cfg_period  (cfg_period),
      .cfg_te_start(cfg_te_start),
      .cfg_te_end  (cfg_te_end),
      .cfg_load    (cfg_load),
`ifdef TE_EXT_SYNC_EN
      .te_ext      (te_ext),
`endif
      .te          (te),
      .frame_req   (frame_req),
      .frame_ack   (frame_ack),
      .frame_done  (frame_done),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .overrun_cnt (overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: frame position, active/pending timing, and where the frame is in its handshake.
   int          mPos, mPer, mTs, mTend, pPer, pTs, pTend, mOvr;
   logic [15:0] mFrames;
   bit          mWait, mReq, mXfer, mTe, mEvt, mTeNext;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mPos = 0; mPer = 1334333; mTs = 100; mTend = 300;
         pPer = 1334333; pTs = 100; pTend = 300;
         mOvr = 0; mFrames = 16'd0;
         mWait = 0; mReq = 0; mXfer = 0; mTe = 0;
      end else begin
         mEvt    = enable && (mPos == mTend);
         mTeNext = enable && (mPos != mPer) && (mPos >= mTs) && !((mTend >= mTs) && (mTend <= mPos));
         if (mXfer) begin
            if (frame_done) begin
               mFrames = mFrames + 16'd1;
               mXfer   = 0;
               if (enable) begin
                  if (mEvt) mReq = 1;
                  else      mWait = 1;
               end
            end else if (mEvt && mOvr < 255) begin
               mOvr++;
            end
         end else if (mReq) begin
            if (mEvt && mOvr < 255) mOvr++;
            if (!enable) mReq = 0;
            else if (frame_ack) begin mReq = 0; mXfer = 1; end
         end else if (mWait) begin
            if (!enable) mWait = 0;
            else if (mEvt) begin mWait = 0; mReq = 1; end
         end else if (enable) begin
            mWait = 1;
         end
         mTe = mTeNext;
         if (!enable || mPos == mPer) begin
            mPos = 0; mPer = pPer; mTs = pTs; mTend = pTend;
         end else begin
            mPos++;
         end
         if (cfg_load) begin
            pPer = int'(cfg_period); pTs = int'(cfg_te_start); pTend = int'(cfg_te_end);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic doReset();
      rstn = 1'b0; enable = 1'b0; cfg_load = 1'b0; frame_ack = 1'b0; frame_done = 1'b0;
      cfg_period = '0; cfg_te_start = '0; cfg_te_end = '0;
      #23;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Loads a timing set while disabled so it is active by the time this returns.
   task automatic loadCfgIdle(input int p, input int ts, input int tend);
      enable = 1'b0;
      cfg_period = CNT_W'(p); cfg_te_start = CNT_W'(ts); cfg_te_end = CNT_W'(tend);
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      doReset();
      checks += 5;
      if (te !== 1'b0) begin errors++; $display("[TB] FAIL reset_te: got %b expected 0", te); end
      if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", frame_req); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_overrun_cnt: got %0d expected 0", overrun_cnt); end
   endtask

   task automatic test_default_te();
      int riseAt, fallAt, reqAt;
      doReset();
      riseAt = -1; fallAt = -1; reqAt = -1;
      enable = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (te === 1'b1 && riseAt < 0) riseAt = k;
         if (te === 1'b0 && riseAt >= 0 && fallAt < 0) fallAt = k;
         if (frame_req === 1'b1 && reqAt < 0) reqAt = k;
      end
      checks += 3;
      if (riseAt != 101) begin errors++; $display("[TB] FAIL default_te_rise: got cycle %0d expected 101", riseAt); end
      if (fallAt != 301) begin errors++; $display("[TB] FAIL default_te_fall: got cycle %0d expected 301", fallAt); end
      if (reqAt != 301) begin errors++; $display("[TB] FAIL default_first_req: got cycle %0d expected 301", reqAt); end
   endtask

   task automatic test_cfg_shadow();
      int rises[$];
      int falls[$];
      int expRise[3];
      int expFall[3];
      logic prevTe;
      expRise = '{101, 2011, 3011};
      expFall = '{301, 2021, 3021};
      doReset();
      loadCfgIdle(1999, 100, 300);
      enable = 1'b1;
      prevTe = 1'b0;
      for (int k = 1; k <= 3030; k++) begin
         @(negedge clk);
         if (te === 1'b1 && prevTe === 1'b0) rises.push_back(k);
         if (te === 1'b0 && prevTe === 1'b1) falls.push_back(k);
         prevTe = te;
         cfg_load = (k == 500);
         if (k == 500) begin
            cfg_period = CNT_W'(999); cfg_te_start = CNT_W'(10); cfg_te_end = CNT_W'(20);
         end
      end
      checks += 2;
      if (rises.size() != 3) begin
         errors++; $display("[TB] FAIL shadow_rise_count: got %0d expected 3", rises.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rises[i] != expRise[i]) begin errors++; $display("[TB] FAIL shadow_rise%0d: got cycle %0d expected %0d", i, rises[i], expRise[i]); end
         end
      end
      if (falls.size() != 3) begin
         errors++; $display("[TB] FAIL shadow_fall_count: got %0d expected 3", falls.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (falls[i] != expFall[i]) begin errors++; $display("[TB] FAIL shadow_fall%0d: got cycle %0d expected %0d", i, falls[i], expFall[i]); end
         end
      end
   endtask

   task automatic test_handshake();
      int reqCycles, busyCycles, firstReq;
      doReset();
      loadCfgIdle(999, 10, 20);
      enable = 1'b1;
      reqCycles = 0; busyCycles = 0; firstReq = -1;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         if (frame_req === 1'b1) begin reqCycles++; if (firstReq < 0) firstReq = k; end
         if (busy === 1'b1) busyCycles++;
         frame_ack  = (k == 23);
         frame_done = (k == 73);
      end
      checks += 5;
      if (firstReq != 21) begin errors++; $display("[TB] FAIL hs_first_req: got cycle %0d expected 21", firstReq); end
      if (reqCycles != 3) begin errors++; $display("[TB] FAIL hs_req_cycles: got %0d expected 3", reqCycles); end
      if (busyCycles != 53) begin errors++; $display("[TB] FAIL hs_busy_cycles: got %0d expected 53", busyCycles); end
      if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL hs_frame_cnt: got %0d expected 1", frame_cnt); end
      if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL hs_overrun: got %0d expected 0", overrun_cnt); end
   endtask

   task automatic test_overrun();
      int reqCycles;
      doReset();
      loadCfgIdle(99, 10, 20);
      enable = 1'b1;
      reqCycles = 0;
      for (int k = 1; k <= 3600; k++) begin
         @(negedge clk);
         if (frame_req === 1'b1) reqCycles++;
         if (k == 330) begin
            checks += 3;
            if (overrun_cnt !== 8'd3) begin errors++; $display("[TB] FAIL ovr_three: got %0d expected 3", overrun_cnt); end
            if (reqCycles != 1) begin errors++; $display("[TB] FAIL ovr_single_req: got %0d req cycles expected 1", reqCycles); end
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_busy_held: got %b expected 1", busy); end
         end
         if (k == 1000) begin
            checks++;
            if (overrun_cnt !== 8'd63) begin errors++; $display("[TB] FAIL ovr_midway: got %0d expected 63", overrun_cnt); end
         end
         frame_ack = (k == 21);
         cfg_load  = (k == 330);
         if (k == 330) begin
            cfg_period = CNT_W'(9); cfg_te_start = CNT_W'(2); cfg_te_end = CNT_W'(4);
         end
      end
      checks += 2;
      if (overrun_cnt !== 8'd255) begin errors++; $display("[TB] FAIL ovr_saturate: got %0d expected 255", overrun_cnt); end
      if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL ovr_frame_cnt: got %0d expected 0", frame_cnt); end
   endtask

   task automatic test_done_coincident();
      doReset();
      loadCfgIdle(9, 2, 4);
      enable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 14) begin
            checks++;
            if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL coinc_pre_req: got %b expected 0", frame_req); end
         end
         if (k == 15) begin
            checks += 4;
            if (frame_req !== 1'b1) begin errors++; $display("[TB] FAIL coinc_req: got %b expected 1", frame_req); end
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL coinc_busy: got %b expected 1", busy); end
            if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL coinc_frame_cnt: got %0d expected 1", frame_cnt); end
            if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL coinc_overrun: got %0d expected 0", overrun_cnt); end
         end
         frame_ack  = (k == 5);
         frame_done = (k == 14);
      end
   endtask

   task automatic test_enable_drop();
      doReset();
      loadCfgIdle(19, 2, 12);
      enable = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         case (k)
            25: begin
               checks++;
               if (te !== 1'b1) begin errors++; $display("[TB] FAIL drop_te_before: got %b expected 1", te); end
            end
            26: begin
               checks += 2;
               if (te !== 1'b0) begin errors++; $display("[TB] FAIL drop_te_low: got %b expected 0", te); end
               if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy_held: got %b expected 1", busy); end
            end
            31: begin
               checks += 2;
               if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy_released: got %b expected 0", busy); end
               if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_frame_cnt: got %0d expected 1", frame_cnt); end
            end
            53: begin
               checks++;
               if (frame_req !== 1'b1) begin errors++; $display("[TB] FAIL drop_rearm_req: got %b expected 1", frame_req); end
            end
            55: begin
               checks += 2;
               if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL drop_req_withdrawn: got %b expected 0", frame_req); end
               if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_req_busy: got %b expected 0", busy); end
            end
            60: begin
               checks += 2;
               if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_ack_ignored: got busy %b expected 0", busy); end
               if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL drop_overrun: got %0d expected 0", overrun_cnt); end
            end
            default: ;
         endcase
         frame_ack  = (k == 13) || (k == 54);
         frame_done = (k == 30);
         if (k == 25) enable = 1'b0;
         if (k == 40) enable = 1'b1;
         if (k == 54) enable = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      doReset();
      loadCfgIdle(9, 2, 4);
      enable = 1'b1;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      checks++;
      if (frame_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req_before: got %b expected 1", frame_req); end
      #2;
      rstn = 1'b0;
      #1;
      checks += 2;
      if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req: got %b expected 0", frame_req); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      doReset();
   endtask

   task automatic test_random();
      int p;
      doReset();
      loadCfgIdle(20, 5, 12);
      enable = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         checks += 5;
         if (te !== mTe) begin errors++; $display("[TB] FAIL rnd_te @%0d: got %b expected %b", k, te, mTe); end
         if (frame_req !== mReq) begin errors++; $display("[TB] FAIL rnd_req @%0d: got %b expected %b", k, frame_req, mReq); end
         if (busy !== (mReq || mXfer)) begin errors++; $display("[TB] FAIL rnd_busy @%0d: got %b expected %b", k, busy, (mReq || mXfer)); end
         if (frame_cnt !== mFrames) begin errors++; $display("[TB] FAIL rnd_frame_cnt @%0d: got %0d expected %0d", k, frame_cnt, mFrames); end
         if (overrun_cnt !== 8'(mOvr)) begin errors++; $display("[TB] FAIL rnd_overrun @%0d: got %0d expected %0d", k, overrun_cnt, mOvr); end
         enable     = ($urandom_range(0, 99) < 97);
         frame_ack  = ($urandom_range(0, 99) < 30);
         frame_done = ($urandom_range(0, 99) < 12);
         cfg_load   = ($urandom_range(0, 99) < 2);
         if (cfg_load) begin
            p = int'($urandom_range(8, 40));
            cfg_period   = CNT_W'(p);
            cfg_te_start = CNT_W'($urandom_range(0, p + 3));
            cfg_te_end   = CNT_W'($urandom_range(0, p + 3));
         end
      end
      frame_ack = 1'b0; frame_done = 1'b0; cfg_load = 1'b0;
   endtask

   initial begin
      $display("[TB] te_frame_sched bench start");
      test_reset();
      test_default_te();
      test_cfg_shadow();
      test_handshake();
      test_overrun();
      test_done_coincident();
      test_enable_drop();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
